// File: rtl/icache_direct_mapped.sv
// Direct-mapped, read-only instruction cache with a 16-byte line.
// Hits return the fetched word combinationally; misses refill one line.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | serving hits; a miss latches the line address
// MEM_READ | block read outstanding; waits for mem_busywait low, fills line
module icache_direct_mapped #(
   parameter int BLOCK_COUNT = 8,
   parameter int TAG_W       = 28 - $clog2(BLOCK_COUNT)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [31:0]  address,
   output logic [31:0]  instruction,
   output logic         busywait,
   output logic         mem_read,
   output logic [27:0]  mem_address,
   input  logic [127:0] mem_readdata,
   input  logic         mem_busywait
);

   localparam int IDX_W = $clog2(BLOCK_COUNT);

   typedef enum logic {
      IDLE     = 1'b0,
      MEM_READ = 1'b1
   } state_t;

   state_t state, state_nxt;

   logic [BLOCK_COUNT-1:0] valid_q;
   logic [TAG_W-1:0]       tag_q  [BLOCK_COUNT];
   logic [127:0]           data_q [BLOCK_COUNT];
   logic [27:0]            miss_addr;

   logic [IDX_W-1:0] idx;
   logic [IDX_W-1:0] miss_idx;
   logic [TAG_W-1:0] addr_tag;
   logic [TAG_W-1:0] miss_tag;
   logic [1:0]       word_sel;
   logic [31:0]      data_word;
   logic             hit;
   logic             fill;
   logic             unused_addr_bits;

   assign idx      = address[4+IDX_W-1:4];
   assign addr_tag = address[31:4+IDX_W];
   assign word_sel = address[3:2];
   assign miss_idx = miss_addr[IDX_W-1:0];
   assign miss_tag = miss_addr[27:IDX_W];

   // byte offset within a word is meaningless for 32-bit fetches
   assign unused_addr_bits = ^address[1:0];

   assign hit       = valid_q[idx] && (tag_q[idx] == addr_tag);
   assign data_word = data_q[idx][{word_sel, 5'd0} +: 32];
   assign fill      = (state == MEM_READ) && !mem_busywait;

   assign mem_address = miss_addr;

   always_comb begin
      state_nxt   = state;
      busywait    = 1'b0;
      mem_read    = 1'b0;
      instruction = data_word;
      case (state)
         IDLE: begin
            busywait = !hit;
            if (!hit) begin
               state_nxt = MEM_READ;
            end
         end
         MEM_READ: begin
            busywait = 1'b1;
            mem_read = 1'b1;
            if (!mem_busywait) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (reset) begin
         busywait    = 1'b0;
         instruction = 32'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         valid_q   <= '0;
         miss_addr <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && !hit) begin
            miss_addr <= address[31:4];
         end
         if (fill) begin
            valid_q[miss_idx] <= 1'b1;
         end
      end
   end

   // tag/data storage carries no reset; valid_q alone guards it
   always_ff @(posedge clk) begin
      if (!reset && fill) begin
         tag_q[miss_idx]  <= miss_tag;
         data_q[miss_idx] <= mem_readdata;
      end
   end

endmodule

// File: tb/tb_icache_direct_mapped.sv
// Randomized scoreboard bench for icache_direct_mapped with a latency-
// programmable instruction memory and a line-granular reference model.
module tb_icache_direct_mapped;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [31:0]  address = 32'd0;
   logic [31:0]  instruction;
   logic         busywait;
   logic         mem_read;
   logic [27:0]  mem_address;
   logic [127:0] mem_readdata;
   logic         mem_busywait;

   int          n_checks = 0;
   int          n_fail = 0;
   int          lat = 3;
   int          mcnt = 0;
   bit          garbage = 1'b0;
   int unsigned seed = 0;

   logic [31:0] exp_q [$];
   bit          m_ok   [8];
   logic [27:0] m_line [8];

   icache_direct_mapped dut (
      .clk          (clk),
      .reset        (reset),
      .address      (address),
      .instruction  (instruction),
      .busywait     (busywait),
      .mem_read     (mem_read),
      .mem_address  (mem_address),
      .mem_readdata (mem_readdata),
      .mem_busywait (mem_busywait)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a, input int unsigned s);
      logic [31:0] w;
      w = {a[31:2], 2'b00};
      return (w * 32'h9E37_79B1) ^ s ^ 32'h1234_5678;
   endfunction

   // memory: answers after lat cycles of mem_read
   always @(posedge clk) mcnt <= mem_read ? mcnt + 1 : 0;

   always @* begin
      mem_busywait = 1'b1;
      mem_readdata = '0;
      if (garbage) begin
         mem_busywait = 1'b0;
         mem_readdata = {4{32'hDEAD_BEEF}};
      end else if (mem_read) begin
         mem_busywait = !(mcnt >= lat - 1);
         for (int k = 0; k < 4; k++)
            mem_readdata[32*k +: 32] = mem_word({mem_address, 4'h0} + 32'(k * 4), seed);
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 8; i++) m_ok[i] = 1'b0;
   endtask

   // Applies a fetch, pushes the expected word, and checks stall length.
   task automatic fetch(input logic [31:0] a, input bit chk_rst);
      int          idx;
      logic [27:0] line;
      bit          hit;
      int          exp_busy;
      int          busy;
      bit          saw_mem;
      bit          first;
      bit          done;
      line = 28'(a / 16);
      idx  = int'((a / 16) % 8);
      hit  = m_ok[idx] && (m_line[idx] == line);
      exp_busy = hit ? 0 : 1 + lat;
      if (!hit) begin
         m_ok[idx]   = 1'b1;
         m_line[idx] = line;
      end
      address = a;
      exp_q.push_back(mem_word(a, seed));
      busy = 0; saw_mem = 0; first = 1; done = 0;
      while (!done) begin
         @(negedge clk);
         if (first && chk_rst) begin
            check("post_reset_mem_read", mem_read, 1'b0);
            check("post_reset_mem_address", mem_address, 28'd0);
         end
         first = 0;
         if (busywait) begin
            busy++;
            if (mem_read && !saw_mem) begin
               check("mem_address", mem_address, line);
               saw_mem = 1;
            end
            if (busy > 60) begin
               n_checks++;
               n_fail++;
               $display("FAIL fetch_timeout: addr %0h still busy after %0d cycles", a, busy);
               exp_q.delete();
               done = 1;
            end
         end else begin
            check("busy_cycles", busy, exp_busy);
            check("mem_read_when_ready", mem_read, 1'b0);
            if (exp_busy > 0) check("mem_request_seen", saw_mem, 1'b1);
            done = 1;
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic reset_then_fetch(input logic [31:0] a);
      reset   = 1'b1;
      address = a;
      repeat (2) begin
         @(negedge clk);
         check("reset_busywait", busywait, 1'b0);
         check("reset_instruction", instruction, 32'd0);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      model_clear();
      fetch(a, 1'b1);
   endtask

   // monitor: compares every word the DUT presents against the scoreboard
   initial begin
      logic [31:0] e;
      forever begin
         @(negedge clk);
         if (!reset && !busywait && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("instruction", instruction, e);
         end
      end
   end

   initial begin
      logic [31:0] x;
      seed = $urandom;
      model_clear();
      @(posedge clk); #1;

      lat = 3;
      reset_then_fetch(32'h0000_0000);
      fetch(32'h0000_0004, 1'b0);
      fetch(32'h0000_0008, 1'b0);
      fetch(32'h0000_000C, 1'b0);

      fetch(32'h0000_0080, 1'b0);
      fetch(32'h0000_0000, 1'b0);

      lat = 1;
      fetch(32'h0000_0140, 1'b0);

      // reset in the 2nd MEM_READ cycle of a 5-cycle miss
      lat = 5;
      x = 32'h0000_3008;
      address = x;
      @(negedge clk);
      check("abort_miss_busy", busywait, 1'b1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      check("abort_mem_read_before", mem_read, 1'b1);
      check("abort_busy_forced", busywait, 1'b0);
      @(posedge clk); #1;
      garbage = 1'b1;
      @(negedge clk);
      check("abort_mem_read_dropped", mem_read, 1'b0);
      @(posedge clk); #1;
      reset   = 1'b0;
      garbage = 1'b0;
      model_clear();
      fetch(x, 1'b1);

      lat = 2;
      for (int i = 0; i < 8; i++) fetch(32'(i * 16), 1'b0);
      for (int w = 0; w < 32; w++) fetch(32'(w * 4), 1'b0);

      repeat (200) begin
         lat = int'($urandom_range(1, 4));
         fetch({22'd0, 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3))}, 1'b0);
      end

      repeat (3) @(negedge clk);
      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/icache_direct_mapped.md
# icache_direct_mapped

Direct-mapped, read-only instruction cache that answers the CPU's fetch port. It takes a byte address and returns the 32-bit instruction, raising `busywait` while it fills a miss. On a miss it reads one 16-byte block from instruction memory over a busywait-handshaked block interface. It sits between the CPU fetch stage and the instruction memory model.

## Interface

Parameters:
- `BLOCK_COUNT`, default 8: number of cache lines; power of two. Index width `IDX_W = log2(BLOCK_COUNT)`.
- `TAG_W`, default `28 - IDX_W`: tag width, equal to `address[31:4+IDX_W]`.

Ports (one clock; reset is synchronous and active-high):
- `clk`: input, 1. Rising-edge clock.
- `reset`: input, 1. Synchronous, active-high.
- `address`: input, 32. CPU fetch byte address. `[1:0]` ignored; `[3:2]` word offset; `[4+IDX_W-1:4]` index; upper bits tag.
- `instruction`: output, 32. Fetched word; valid when `busywait`=0.
- `busywait`: output, 1. CPU must stall and hold `address` while high.
- `mem_read`: output, 1. Block read request to instruction memory.
- `mem_address`: output, 28. Block address (`address[31:4]` of the missing line).
- `mem_readdata`: input, 128. Block data; word k at `[32k+31:32k]`.
- `mem_busywait`: input, 1. Memory busy; data is valid in the cycle `mem_read`=1 and `mem_busywait`=0.

## Operation

- Storage per line: `valid` bit, `TAG_W` tag, 128-bit data. Arrays are registered; reads are combinational.
- `hit = valid[idx] && tag[idx] == address_tag`. `instruction = data[idx]` word `address[3:2]`, combinational.
- FSM states:
  - IDLE:
    - `busywait = !hit`, `mem_read` = 0.
    - On miss (`!hit`, `reset` = 0): latch `address[31:4]` into `miss_addr` and go to MEM_READ.
  - MEM_READ:
    - `busywait` = 1, `mem_read` = 1, `mem_address = miss_addr`.
    - Stay while `mem_busywait` = 1.
    - When `mem_busywait` = 0, on that edge: write `mem_readdata` into `data[miss_idx]`, write `tag[miss_idx] = miss_tag`, set `valid[miss_idx]` = 1. Then go to IDLE.
- Refill targets `miss_addr`, not the live `address`. If the CPU changes `address` during MEM_READ (a protocol violation), the latched line is still filled. IDLE then re-evaluates the new address.
- Write-free: no dirty state, no write port. A refill overwrites the line unconditionally.
- Reset, including mid-MEM_READ:
  - On the edge: all `valid` cleared, state = IDLE, `mem_read` = 0, `miss_addr` = 0.
  - The memory request is abandoned. Any `mem_readdata` arriving later is ignored.
  - Tag and data arrays need not be cleared.
- During any cycle with `reset` = 1, `busywait` is forced to 0 and `instruction` to 0.

## Timing

- Outputs after reset: `busywait` = 1 (all lines invalid) unless `reset` is still high, `mem_read` = 0, `mem_address` = 0, `instruction` = don't-care while `busywait` = 1.
- Hit latency: 0 cycles. `instruction` is valid in the same cycle `address` is applied, and `busywait` = 0.
- Miss timing, address applied in cycle N:
  - Cycle N: `busywait` = 1.
  - Cycles N+1..N+L: MEM_READ, where L ≥ 1 is the number of cycles until `mem_busywait` is low.
  - Cycle N+L+1: IDLE, hit, `busywait` = 0, correct `instruction`.
  - Minimum miss penalty: 2 busywait cycles (memory answers in its first cycle).
- `mem_read` and `mem_address` are registered-state outputs. They are stable for the whole of MEM_READ and drop in the cycle after data capture.
- No back-to-back request: at least one IDLE cycle separates successive refills.

## Test plan

- Reset then fetch `0x00000000`, memory latency 3:
  - `busywait` high for 4 cycles.
  - `mem_address` = `0x0000000`.
  - `instruction` = `mem_readdata[31:0]`.
- Sequential fetch `0x04`, `0x08`, `0x0C` after that refill: all hits, `busywait` = 0 every cycle, words 1..3 of the block, `mem_read` never asserted.
- Conflict on BLOCK_COUNT=8:
  - Fetch `0x00`, then `0x80` (same index 0, different tag): second fetch misses with `mem_address` = `0x0000008`.
  - Fetch `0x00` again: misses again.
- Memory answers in the first MEM_READ cycle (L=1): `busywait` high exactly 2 cycles, data correct in cycle 3.
- Reset asserted in the 2nd MEM_READ cycle of a 5-cycle miss:
  - Next cycle `mem_read` = 0.
  - Late `mem_readdata` is ignored.
  - Refetch of the same address misses again.
- Fill all 8 lines (`0x00`, `0x10`…`0x70`), then sweep all 32 words: zero misses, each `instruction` matches the preloaded memory image.
